// File: rtl/color_config_ctrl_pkg.sv
// Shared VGA colour/line configuration definitions: controller states,
// power-on defaults for the tone and line-position registers, and the
// saturating line-position step helper.
package color_config_ctrl_pkg;

  localparam int         DEB_CYCLES_DEF = 4;
  localparam logic [7:0] TONO_INIT_DEF  = 8'hE0;  // RRRGGGBB
  localparam int         LP_INIT_DEF    = 240;
  localparam int         LP_MAX_DEF     = 479;
  localparam int         LP_STEP_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_COMMIT     = 2'd2,
    ST_HOLD       = 2'd3
  } state_t;

  // Widened to 10 bits so pos + step cannot wrap before the limit compare.
  function automatic logic [8:0] line_step(input logic [8:0] pos,
                                           input logic       up,
                                           input logic [9:0] step,
                                           input logic [9:0] max);
    logic [9:0] wide;
    wide = {1'b0, pos};
    if (up) begin
      wide = wide + step;
      if (wide > max) wide = max;
    end else begin
      if (wide < step) wide = '0;
      else             wide = wide - step;
    end
    return wide[8:0];
  endfunction

endpackage

// File: rtl/color_config_ctrl_btn_filtro.sv
// Button debounce filter: output follows raw only after it has differed
// for DEB_CYCLES+1 consecutive clocks; no backpressure.
// Ports: clk_i, rst_n_i (sync, active-low), raw_i -> filt_o.
module btn_filtro #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Counter runs only while raw disagrees with the filtered level; any
  // agreement clears it, so short glitches never reach the output.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (raw_i != filt_q) begin
      if (cnt_q == CW'(DEB_CYCLES)) filt_d = raw_i;
      else                          cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/color_config_ctrl.sv
// Colour/line configuration controller: debounced Up/Down with TC/Lp select
// queue one change, applied on the next Vblank edge (latency = to next Vblank
// + 1 edge); commands arriving while busy are dropped.
// Ports: Clock, reset (sync, active-low), Up, Down, TC, Lp, Vblank ->
//        Tono[7:0], PosLinea[8:0], Busy, Actualizado (one-cycle commit pulse).
module color_config_ctrl
  import color_config_ctrl_pkg::*;
#(
  parameter int         DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic [7:0] TONO_INIT  = TONO_INIT_DEF,
  parameter int         LP_INIT    = LP_INIT_DEF,
  parameter int         LP_MAX     = LP_MAX_DEF,
  parameter int         LP_STEP    = LP_STEP_DEF
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       Up,
  input  logic       Down,
  input  logic       TC,
  input  logic       Lp,
  input  logic       Vblank,
  output logic [7:0] Tono,
  output logic [8:0] PosLinea,
  output logic       Busy,
  output logic       Actualizado
);

  localparam logic [8:0] LP_INIT_W = 9'(LP_INIT);
  localparam logic [9:0] LP_MAX_W  = 10'(LP_MAX);
  localparam logic [9:0] LP_STEP_W = 10'(LP_STEP);

  logic up_f, down_f, tc_f, lp_f;

  btn_filtro #(.DEB_CYCLES(DEB_CYCLES)) u_f_up   (.clk_i(Clock), .rst_n_i(reset), .raw_i(Up),   .filt_o(up_f));
  btn_filtro #(.DEB_CYCLES(DEB_CYCLES)) u_f_down (.clk_i(Clock), .rst_n_i(reset), .raw_i(Down), .filt_o(down_f));
  btn_filtro #(.DEB_CYCLES(DEB_CYCLES)) u_f_tc   (.clk_i(Clock), .rst_n_i(reset), .raw_i(TC),   .filt_o(tc_f));
  btn_filtro #(.DEB_CYCLES(DEB_CYCLES)) u_f_lp   (.clk_i(Clock), .rst_n_i(reset), .raw_i(Lp),   .filt_o(lp_f));

  state_t     state_q, state_d;
  logic       up_prev_q, down_prev_q;
  logic       tgt_line_q, tgt_line_d;  // 1: line position, 0: tone
  logic       dir_up_q, dir_up_d;
  logic [7:0] tono_q, tono_d;
  logic [8:0] pos_q, pos_d;

  logic up_rise, down_rise, cmd;

  assign up_rise   = up_f & ~up_prev_q;
  assign down_rise = down_f & ~down_prev_q;
  // Exactly one direction edge and exactly one target select.
  assign cmd       = (up_rise ^ down_rise) & (tc_f ^ lp_f);

  always_comb begin
    state_d     = state_q;
    tgt_line_d  = tgt_line_q;
    dir_up_d    = dir_up_q;
    tono_d      = tono_q;
    pos_d       = pos_q;
    Actualizado = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd) begin
          state_d    = ST_WAIT_FRAME;
          tgt_line_d = lp_f;
          dir_up_d   = up_rise;
        end
      end
      ST_WAIT_FRAME: begin
        // Outputs move only at the frame boundary so a frame is never torn.
        if (Vblank) begin
          state_d = ST_COMMIT;
          if (tgt_line_q) pos_d  = line_step(pos_q, dir_up_q, LP_STEP_W, LP_MAX_W);
          else            tono_d = dir_up_q ? tono_q + 8'd1 : tono_q - 8'd1;
        end
      end
      ST_COMMIT: begin
        Actualizado = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        // Wait for the buttons to be released so one press gives one step.
        if (!up_f && !down_f) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      tgt_line_q  <= 1'b0;
      dir_up_q    <= 1'b0;
      tono_q      <= TONO_INIT;
      pos_q       <= LP_INIT_W;
    end else begin
      state_q     <= state_d;
      up_prev_q   <= up_f;
      down_prev_q <= down_f;
      tgt_line_q  <= tgt_line_d;
      dir_up_q    <= dir_up_d;
      tono_q      <= tono_d;
      pos_q       <= pos_d;
    end
  end

  assign Tono     = tono_q;
  assign PosLinea = pos_q;
  assign Busy     = (state_q != ST_IDLE);

endmodule

// File: doc/color_config_ctrl.md
COLOR_CONFIG_CTRL -- requirements
Module: color_config_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive cycles an input must differ from its filtered value before the filtered value changes.
REQ-002 Parameter TONO_INIT, default 8'hE0: reset value of the tone register (RRRGGGBB).
REQ-003 Parameter LP_INIT, default 240: reset value of the line-position register.
REQ-004 Parameter LP_MAX, default 479: upper saturation limit of the line position.
REQ-005 Parameter LP_STEP, default 8: line-position change per command.
REQ-006 Clock  in  1  single system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 Up  in  1  raw increment button.
REQ-009 Down  in  1  raw decrement button.
REQ-010 TC  in  1  raw select: tone register.
REQ-011 Lp  in  1  raw select: line-position register.
REQ-012 Vblank  in  1  one-cycle frame-boundary pulse from the VGA timing generator.
REQ-013 Tono  out  8  active tone, Rojo=[7:5], Verde=[4:2], Azul=[1:0].
REQ-014 PosLinea  out  9  active line position, 0..LP_MAX.
REQ-015 Busy  out  1  high when not in IDLE.
REQ-016 Actualizado  out  1  one-cycle pulse when a change is committed.

Function
REQ-017 Each of Up, Down, TC, Lp SHALL pass through its own filter: counter increments while raw != filtered, clears otherwise; filtered toggles when count reaches DEB_CYCLES.
REQ-018 Filter output SHALL change exactly DEB_CYCLES+1 cycles after a stable raw edge; glitches shorter than DEB_CYCLES cycles SHALL be ignored.
REQ-019 A command SHALL be detected in IDLE on a rising edge of filtered Up XOR a rising edge of filtered Down, with exactly one of filtered TC/Lp high in the same cycle.
REQ-020 Simultaneous Up and Down edges, TC and Lp both high, or neither high SHALL produce no command and FSM stays IDLE.
REQ-021 FSM states: IDLE, WAIT_FRAME, COMMIT, HOLD.
REQ-022 IDLE -> WAIT_FRAME on command; target (tone/line) and direction latched into pending registers.
REQ-023 WAIT_FRAME -> COMMIT on the cycle Vblank=1; Tono/PosLinea update at that same clock edge.
REQ-024 COMMIT lasts exactly one cycle with Actualizado=1, then -> HOLD.
REQ-025 HOLD -> IDLE when filtered Up and Down are both low; new commands ignored while not IDLE.
REQ-026 Tone arithmetic: Tono +/- 1 modulo 256 (8'hFF+1 = 8'h00, 8'h00-1 = 8'hFF).
REQ-027 Line arithmetic: PosLinea +/- LP_STEP saturating at 0 and LP_MAX, computed in 10 bits.
REQ-028 Tono and PosLinea SHALL change only in the WAIT_FRAME->COMMIT transition; never mid-frame.
REQ-029 Vblank in any state other than WAIT_FRAME SHALL have no effect.
REQ-030 Latency: command detection to output change = cycles until next Vblank pulse + 1 edge.

Reset
REQ-031 With reset=0 at a rising edge: Tono=TONO_INIT, PosLinea=LP_INIT, Busy=0, Actualizado=0, state=IDLE, filters and counters=0, pending command discarded.
REQ-032 Reset asserted mid-operation (any state) SHALL abandon the pending command with no output update.

Structure
REQ-033 State encoding, TONO_INIT/LP_INIT/LP_MAX/LP_STEP defaults SHALL live in the shared VGA package/header used by controlvga_principal.
REQ-034 The filter SHALL be one sub-module, btn_filtro, instantiated four times.

Verification
REQ-035 Reset release, no buttons, 3 Vblank pulses -> Tono=8'hE0, PosLinea=240, Actualizado never high.
REQ-036 TC+Up held 10 cycles, Vblank 100 cycles later -> Tono unchanged until Vblank, then 8'hE1, one Actualizado pulse.
REQ-037 Lp+Down held 10 cycles from PosLinea=4, Vblank -> PosLinea=0; Lp+Up from 476 -> 479.
REQ-038 TC+Up from Tono=8'hFF -> 8'h00; 2-cycle glitch on Up with TC high -> no command.
REQ-039 TC and Lp both high with Up -> no change, Busy stays 0; Up and Down together -> no change.
REQ-040 Command issued, reset=0 asserted in WAIT_FRAME, then Vblank -> outputs at reset values, no Actualizado.
